// File: rtl/dds_pkg.sv
// Shared MIDI constants, parser state encoding and the note event record
// passed from the byte parser to the voice allocator.
package dds_pkg;

    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [7:0] RT_MIN        = 8'hF8;

    typedef enum logic [1:0] {
        P_IDLE,
        P_DATA1,
        P_DATA2
    } parser_state_e;

    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic [6:0] vel;
    } midi_event_t;

endpackage

// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser: note-on/off with running status, realtime bytes
// transparent, emits a one-cycle event strobe after the velocity byte.
module midi_note_parser
    import dds_pkg::*;
#(
    parameter int unsigned MIDI_CH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        ready_o,
    output logic        ev_valid_o,
    output midi_event_t ev_o
);

    parser_state_e state_q;
    logic          rs_valid_q;
    logic [3:0]    rs_cmd_q;
    logic [6:0]    note_q;
    logic          ready_q;
    logic          ev_valid_q;
    midi_event_t   ev_q;

    logic accept;
    logic ch_ok;
    logic is_note_cmd;

    assign accept      = byte_valid_i & ready_q;
    assign ch_ok       = (MIDI_CH >= 16) || (byte_i[3:0] == 4'(MIDI_CH));
    assign is_note_cmd = (byte_i[7:4] == MIDI_NOTE_ON) || (byte_i[7:4] == MIDI_NOTE_OFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= P_IDLE;
            rs_valid_q <= 1'b0;
            rs_cmd_q   <= '0;
            note_q     <= '0;
            ready_q    <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_q       <= '0;
        end else begin
            ready_q    <= 1'b1;
            ev_valid_q <= 1'b0;
            if (accept && (byte_i < RT_MIN)) begin
                if (byte_i[7]) begin
                    if (is_note_cmd && ch_ok) begin
                        rs_valid_q <= 1'b1;
                        rs_cmd_q   <= byte_i[7:4];
                        state_q    <= P_DATA1;
                    end else begin
                        rs_valid_q <= 1'b0;
                        state_q    <= P_IDLE;
                    end
                end else begin
                    // A data byte in IDLE with running status restarts a message as its note byte.
                    case (state_q)
                        P_IDLE: begin
                            if (rs_valid_q) begin
                                note_q  <= byte_i[6:0];
                                state_q <= P_DATA2;
                            end
                        end
                        P_DATA1: begin
                            note_q  <= byte_i[6:0];
                            state_q <= P_DATA2;
                        end
                        P_DATA2: begin
                            ev_valid_q <= 1'b1;
                            ev_q.on    <= (rs_cmd_q == MIDI_NOTE_ON) && (byte_i[6:0] != 7'd0);
                            ev_q.note  <= note_q;
                            ev_q.vel   <= byte_i[6:0];
                            state_q    <= P_IDLE;
                        end
                        default: state_q <= P_IDLE;
                    endcase
                end
            end
        end
    end

    assign ready_o    = ready_q;
    assign ev_valid_o = ev_valid_q;
    assign ev_o       = ev_q;

endmodule

// File: rtl/poly_dds_voice_engine.sv
// Polyphonic DDS voice engine: voice allocation with round-robin stealing,
// per-tick sweep of one shared wavetable ROM and velocity-weighted mixing.
module poly_dds_voice_engine
    import dds_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned WSEL_W     = 3,
    parameter int unsigned SAMPLE_W   = 24,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned SAMPLE_DIV = 101,
    parameter int unsigned MIDI_CH    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     midi_valid,
    input  logic [7:0]               midi_data,
    output logic                     midi_ready,
    output logic [6:0]               inc_note,
    input  logic [PHASE_W-1:0]       inc_word,
    input  logic [WSEL_W-1:0]        wave_sel,
    output logic [WSEL_W+ADDR_W-1:0] rom_addr,
    input  logic [SAMPLE_W-1:0]      rom_data,
    output logic [OUT_W-1:0]         sample_out,
    output logic                     sample_valid,
    output logic [NUM_VOICES-1:0]    voice_active,
    output logic [7:0]               led
);

    localparam int unsigned VIDX_W = $clog2(NUM_VOICES);
    localparam int unsigned ACC_W  = SAMPLE_W + 7 + VIDX_W;
    localparam int unsigned PROD_W = SAMPLE_W + 7;
    localparam int unsigned CNT_W  = $clog2(SAMPLE_DIV);

    logic                  ev_valid;
    midi_event_t           ev;

    logic [NUM_VOICES-1:0] active_q;
    logic [6:0]            note_q  [NUM_VOICES];
    logic [6:0]            vel_q   [NUM_VOICES];
    logic [PHASE_W-1:0]    inc_q   [NUM_VOICES];
    logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
    logic [VIDX_W-1:0]     steal_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WSEL_W-1:0]     wsel_q;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      acc_d;
    logic [OUT_W-1:0]      sample_q;
    logic                  valid_q;
    logic [6:0]            led_q;

    midi_note_parser #(
        .MIDI_CH (MIDI_CH)
    ) u_parser (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (midi_valid),
        .byte_i       (midi_data),
        .ready_o      (midi_ready),
        .ev_valid_o   (ev_valid),
        .ev_o         (ev)
    );

    logic              hit;
    logic              free;
    logic [VIDX_W-1:0] hit_idx;
    logic [VIDX_W-1:0] free_idx;
    logic [VIDX_W-1:0] tgt_idx;

    always_comb begin
        hit      = 1'b0;
        free     = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (!hit && active_q[v] && (note_q[v] == ev.note)) begin
                hit     = 1'b1;
                hit_idx = VIDX_W'(v);
            end
            if (!free && !active_q[v]) begin
                free     = 1'b1;
                free_idx = VIDX_W'(v);
            end
        end
        tgt_idx = hit ? hit_idx : (free ? free_idx : steal_q);
    end

    // Address phase of voice k is at count k; its ROM word returns at count k+1.
    logic              sweep_addr;
    logic              sweep_acc;
    logic [VIDX_W-1:0] addr_v;
    logic [VIDX_W-1:0] acc_v;
    logic [PROD_W-1:0] prod;

    assign sweep_addr = !reset && (cnt_q < CNT_W'(NUM_VOICES));
    assign sweep_acc  = (cnt_q != '0) && (cnt_q <= CNT_W'(NUM_VOICES));
    assign addr_v     = VIDX_W'(cnt_q);
    assign acc_v      = VIDX_W'(cnt_q - CNT_W'(1));

    always_comb begin
        prod  = PROD_W'(rom_data) * PROD_W'(vel_q[acc_v]);
        acc_d = acc_q + (active_q[acc_v] ? ACC_W'(prod) : '0);
    end

    assign rom_addr = sweep_addr
                    ? {((cnt_q == '0) ? wave_sel : wsel_q), phase_q[addr_v][PHASE_W-1 -: ADDR_W]}
                    : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                note_q[v]  <= '0;
                vel_q[v]   <= '0;
                inc_q[v]   <= '0;
                phase_q[v] <= '0;
            end
            steal_q  <= '0;
            cnt_q    <= '0;
            wsel_q   <= '0;
            acc_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            led_q    <= '0;
        end else begin
            cnt_q   <= (cnt_q == CNT_W'(SAMPLE_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
            valid_q <= 1'b0;
            if (cnt_q == '0) begin
                acc_q  <= '0;
                wsel_q <= wave_sel;
            end
            if (sweep_acc) begin
                acc_q <= acc_d;
                if (active_q[acc_v]) begin
                    phase_q[acc_v] <= phase_q[acc_v] + inc_q[acc_v];
                end
                if (cnt_q == CNT_W'(NUM_VOICES)) begin
                    sample_q <= acc_d[ACC_W-1 -: OUT_W];
                    valid_q  <= 1'b1;
                end
            end
            // Placed after the sweep so an event on the voice being advanced overrides it.
            if (ev_valid) begin
                if (ev.on) begin
                    active_q[tgt_idx] <= 1'b1;
                    note_q[tgt_idx]   <= ev.note;
                    vel_q[tgt_idx]    <= ev.vel;
                    inc_q[tgt_idx]    <= inc_word;
                    phase_q[tgt_idx]  <= '0;
                    led_q             <= ev.vel;
                    if (!hit && !free) begin
                        steal_q <= (steal_q == VIDX_W'(NUM_VOICES - 1)) ? '0 : steal_q + VIDX_W'(1);
                    end
                end else begin
                    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                        if (active_q[v] && (note_q[v] == ev.note)) begin
                            active_q[v] <= 1'b0;
                            phase_q[v]  <= '0;
                        end
                    end
                end
            end
        end
    end

    assign inc_note     = ev.note;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign voice_active = active_q;
    assign led          = {1'b0, led_q};

endmodule
